// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: Moore FSM FETCH/DCD/EXE/MEM/WB with memory handshakes.
// Optional MC_CTRL_PERF_EN adds a retired-instruction counter output instr_cnt.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        Zero,
  input  logic        im_ready,
  input  logic        dm_ready,
  output logic        im_req,
  output logic        dm_req,
  output logic        PCWr,
  output logic        IRWr,
  output logic        GRFWr,
  output logic        DMWr,
  output logic [1:0]  NPCOp,
  output logic [1:0]  ALUOp,
  output logic [1:0]  A3Sel,
  output logic [1:0]  WDSel,
  output logic        BSel,
  output logic        EXTOp,
  output logic        illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {FETCH = 3'd0, DCD = 3'd1, EXE = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  typedef enum logic [3:0] {I_NOP, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_JR, I_JAL, I_ILL} instr_t;

  state_t state_reg, state_next;
  instr_t instr;
  logic   retire;

  always_comb begin
    instr = I_ILL;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h00: instr = I_NOP;
          6'h21: instr = I_ADDU;
          6'h23: instr = I_SUBU;
          6'h08: instr = I_JR;
          default: instr = I_ILL;
        endcase
      end
      6'h0D: instr = I_ORI;
      6'h0F: instr = I_LUI;
      6'h23: instr = I_LW;
      6'h2B: instr = I_SW;
      6'h04: instr = I_BEQ;
      6'h03: instr = I_JAL;
      default: instr = I_ILL;
    endcase
  end

  // Each ready is only looked at in its own state, so stray or overlapping readies are harmless.
  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      FETCH: if (im_ready) state_next = DCD;
      DCD: begin
        case (instr)
          I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_JR: state_next = EXE;
          I_JAL:   state_next = WB;
          I_NOP:   begin state_next = FETCH; retire = 1'b1; end
          default: state_next = FETCH;
        endcase
      end
      EXE: begin
        case (instr)
          I_ADDU, I_SUBU, I_ORI, I_LUI: state_next = WB;
          I_LW, I_SW: state_next = MEM;
          default: begin state_next = FETCH; retire = 1'b1; end
        endcase
      end
      MEM: begin
        if (dm_ready) begin
          if (instr == I_LW) begin
            state_next = WB;
          end else begin
            state_next = FETCH;
            retire     = 1'b1;
          end
        end
      end
      WB: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

  // Outputs are gated by reset so they drop the instant reset goes low.
  always_comb begin
    im_req  = 1'b0;
    dm_req  = 1'b0;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    GRFWr   = 1'b0;
    DMWr    = 1'b0;
    NPCOp   = 2'b00;
    ALUOp   = 2'b00;
    A3Sel   = 2'b00;
    WDSel   = 2'b00;
    BSel    = 1'b0;
    EXTOp   = 1'b0;
    illegal = 1'b0;
    if (reset) begin
      case (state_reg)
        FETCH: begin
          im_req = 1'b1;
          PCWr   = im_ready;
          IRWr   = im_ready;
        end
        DCD: illegal = (instr == I_ILL);
        EXE, MEM: begin
          case (instr)
            I_SUBU: ALUOp = 2'b01;
            I_ORI:  begin ALUOp = 2'b10; BSel = 1'b1; end
            I_LW, I_SW: begin BSel = 1'b1; EXTOp = 1'b1; end
            I_BEQ:  begin ALUOp = 2'b01; NPCOp = 2'b01; PCWr = Zero; end
            I_JR:   begin NPCOp = 2'b11; PCWr = 1'b1; end
            default: ;
          endcase
          if (state_reg == MEM) begin
            dm_req = 1'b1;
            DMWr   = (instr == I_SW);
          end
        end
        WB: begin
          GRFWr = 1'b1;
          case (instr)
            I_ORI: A3Sel = 2'b01;
            I_LUI: begin A3Sel = 2'b01; WDSel = 2'b11; end
            I_LW:  begin A3Sel = 2'b01; WDSel = 2'b01; end
            I_JAL: begin A3Sel = 2'b10; WDSel = 2'b10; NPCOp = 2'b10; PCWr = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt_reg <= 32'd0;
    else if (retire) cnt_reg <= cnt_reg + 32'd1;
  end

  assign instr_cnt = cnt_reg;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: one compare per cycle on the packed output vector.
// Define MC_CTRL_PERF_EN to also exercise the instr_cnt wrap.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        Zero, im_ready, dm_ready;
  logic        im_req, dm_req, PCWr, IRWr, GRFWr, DMWr;
  logic [1:0]  NPCOp, ALUOp, A3Sel, WDSel;
  logic        BSel, EXTOp, illegal;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
    .im_ready(im_ready), .dm_ready(dm_ready), .im_req(im_req), .dm_req(dm_req),
    .PCWr(PCWr), .IRWr(IRWr), .GRFWr(GRFWr), .DMWr(DMWr), .NPCOp(NPCOp),
    .ALUOp(ALUOp), .A3Sel(A3Sel), .WDSel(WDSel), .BSel(BSel), .EXTOp(EXTOp),
    .illegal(illegal)
`ifdef MC_CTRL_PERF_EN
    , .instr_cnt(instr_cnt)
`endif
  );

  logic [16:0] obs;
  assign obs = {im_req, dm_req, PCWr, IRWr, GRFWr, DMWr, NPCOp, ALUOp, A3Sel, WDSel, BSel, EXTOp, illegal};

  // Pack expected fields in the same order as obs.
  function automatic logic [16:0] ov(input logic im, dm, pc, ir, grf, dmw,
                                     input logic [1:0] npc, alu, a3, wd,
                                     input logic b, ext, ill);
    return {im, dm, pc, ir, grf, dmw, npc, alu, a3, wd, b, ext, ill};
  endfunction

  task automatic chk(input string tag, input logic [16:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the current cycle's outputs shortly after the falling edge, then move to the next cycle.
  task automatic cyc(input string tag, input logic [16:0] exp);
    #1;
    chk(tag, exp);
    @(negedge clk);
  endtask

  task automatic setop(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  logic [16:0] f_go, f_wait, idle;

  initial begin
    f_go   = ov(1,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
    f_wait = ov(1,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
    idle   = '0;

    reset = 1'b0; opcode = 6'h00; funct = 6'h21; Zero = 1'b0;
    im_ready = 1'b1; dm_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1 chk("reset_outputs", idle);
    @(negedge clk);
    reset = 1'b1;
    im_ready = 1'b0;
    cyc("fetch_after_reset_wait", f_wait);

    // addu with both readies high (dm_ready must be ignored in FETCH)
    im_ready = 1'b1;
    cyc("addu_fetch", f_go);
    cyc("addu_dcd", idle);
    cyc("addu_exe", idle);
    cyc("addu_wb", ov(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,0,0,0));
    im_ready = 1'b0;
    cyc("addu_next_fetch_cycle5", f_wait);

    // subu
    im_ready = 1'b1; setop(6'h00, 6'h23);
    cyc("subu_fetch", f_go);
    cyc("subu_dcd", idle);
    cyc("subu_exe", ov(0,0,0,0,0,0,2'b00,2'b01,2'b00,2'b00,0,0,0));
    cyc("subu_wb", ov(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,0,0,0));

    // lw with dm_ready delayed 2 cycles
    setop(6'h23, 6'h00); dm_ready = 1'b0;
    cyc("lw_fetch", f_go);
    cyc("lw_dcd", idle);
    cyc("lw_exe", ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,1,0));
    cyc("lw_mem_wait1", ov(0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,1,0));
    cyc("lw_mem_wait2", ov(0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,1,0));
    dm_ready = 1'b1;
    cyc("lw_mem_done", ov(0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,1,0));
    cyc("lw_wb", ov(0,0,0,0,1,0,2'b00,2'b00,2'b01,2'b01,0,0,0));

    // sw with immediate dm_ready
    setop(6'h2B, 6'h00);
    cyc("sw_fetch", f_go);
    cyc("sw_dcd", idle);
    cyc("sw_exe", ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,1,0));
    cyc("sw_mem", ov(0,1,0,0,0,1,2'b00,2'b00,2'b00,2'b00,1,1,0));

    // ori
    setop(6'h0D, 6'h00);
    cyc("ori_fetch", f_go);
    cyc("ori_dcd", idle);
    cyc("ori_exe", ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,1,0,0));
    cyc("ori_wb", ov(0,0,0,0,1,0,2'b00,2'b00,2'b01,2'b00,0,0,0));

    // lui
    setop(6'h0F, 6'h00);
    cyc("lui_fetch", f_go);
    cyc("lui_dcd", idle);
    cyc("lui_exe", idle);
    cyc("lui_wb", ov(0,0,0,0,1,0,2'b00,2'b00,2'b01,2'b11,0,0,0));

    // beq taken then not taken
    setop(6'h04, 6'h00); Zero = 1'b1;
    cyc("beq_t_fetch", f_go);
    cyc("beq_t_dcd", idle);
    cyc("beq_t_exe", ov(0,0,1,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0,0));
    Zero = 1'b0;
    cyc("beq_n_fetch", f_go);
    cyc("beq_n_dcd", idle);
    cyc("beq_n_exe", ov(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0,0));

    // jr
    setop(6'h00, 6'h08);
    cyc("jr_fetch", f_go);
    cyc("jr_dcd", idle);
    cyc("jr_exe", ov(0,0,1,0,0,0,2'b11,2'b00,2'b00,2'b00,0,0,0));

    // jal
    setop(6'h03, 6'h00);
    cyc("jal_fetch", f_go);
    cyc("jal_dcd", idle);
    cyc("jal_wb", ov(0,0,1,0,1,0,2'b10,2'b00,2'b10,2'b10,0,0,0));

    // illegal opcode and illegal R-type funct
    setop(6'h3F, 6'h00);
    cyc("ill_op_fetch", f_go);
    cyc("ill_op_dcd", ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,1));
    setop(6'h00, 6'h3F);
    cyc("ill_fn_fetch", f_go);
    cyc("ill_fn_dcd", ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,1));

    // nop
    setop(6'h00, 6'h00);
    cyc("nop_fetch", f_go);
    cyc("nop_dcd", idle);

    // reset in the middle of a stalled sw MEM
    setop(6'h2B, 6'h00); dm_ready = 1'b0;
    cyc("swr_fetch", f_go);
    cyc("swr_dcd", idle);
    cyc("swr_exe", ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,1,0));
    #1 chk("swr_mem_stall", ov(0,1,0,0,0,1,2'b00,2'b00,2'b00,2'b00,1,1,0));
    #1 reset = 1'b0;
    #1 chk("swr_reset_async_zero", idle);
    @(negedge clk);
    dm_ready = 1'b1; im_ready = 1'b0;
    #1 chk("swr_reset_held", idle);
    reset = 1'b1;
    @(negedge clk);
    cyc("swr_after_release_fetch", f_wait);
    cyc("swr_no_dmwr", f_wait);

`ifdef MC_CTRL_PERF_EN
    dut.cnt_reg = 32'hFFFF_FFFF;
    setop(6'h00, 6'h00); im_ready = 1'b1;
    cyc("cnt_nop_fetch", f_go);
    cyc("cnt_nop_dcd", idle);
    #1;
    n_checks++;
    assert (instr_cnt === 32'h0) else begin
      n_fail++;
      $error("FAIL cnt_wrap observed=%h expected=%h", instr_cnt, 32'h0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL: opcode  input  6  instruction opcode from the instruction register.
REQ-004 SHALL: funct  input  6  R-type funct field from the instruction register.
REQ-005 SHALL: Zero  input  1  ALU equality flag.
REQ-006 SHALL: im_ready / dm_ready  input  1 each  memory access-complete handshakes.
REQ-007 SHALL: im_req / dm_req  output  1 each  memory access requests.
REQ-008 SHALL: PCWr, IRWr, GRFWr, DMWr  output  1 each  write enables.
REQ-009 SHALL: NPCOp  output  2  next-PC select: 00 PC+4, 01 branch, 10 jal, 11 jr.
REQ-010 SHALL: ALUOp  output  2  ALU operation: 00 add, 01 sub, 10 or, 11 reserved.
REQ-011 SHALL: A3Sel  output  2  write-register select: 00 rd, 01 rt, 10 $ra.
REQ-012 SHALL: WDSel  output  2  write-data select: 00 C, 01 D, 10 PC4, 11 imm32.
REQ-013 SHALL: BSel, EXTOp  output  1 each  ALU-B immediate select; sign-extend select.
REQ-014 SHALL: illegal  output  1  one-cycle pulse on an undecodable instruction.

Function
REQ-015 SHALL: implement a Moore FSM: FETCH=0, DCD=1, EXE=2, MEM=3, WB=4; all outputs decode from the state plus opcode/funct.
REQ-016 SHALL: FETCH asserts im_req; it holds there while im_ready=0; on im_ready=1 it pulses PCWr (NPCOp=00) and IRWr, then goes to DCD.
REQ-017 SHALL: DCD goes to EXE for addu(0/21h), subu(0/23h), ori(0Dh), lui(0Fh), lw(23h), sw(2Bh), beq(04h) and jr(0/08h).
REQ-018 SHALL: DCD goes to WB for jal(03h).
REQ-019 SHALL: DCD goes to FETCH with no enables for nop (opcode 0, funct 0).
REQ-020 SHALL: DCD goes to FETCH for any other encoding, pulsing illegal with no write enables.
REQ-021 SHALL: EXE drives ALUOp/BSel/EXTOp: addu 00/0; subu 01/0; ori 10/1, EXTOp=0; lw and sw 00/1, EXTOp=1; beq 01/0.
REQ-022 SHALL: EXE routes addu, subu, ori and lui to WB, and lw and sw to MEM.
REQ-023 SHALL: EXE for beq asserts NPCOp=01 and PCWr=Zero, then goes to FETCH.
REQ-024 SHALL: EXE for jr asserts NPCOp=11 and PCWr=1, then goes to FETCH.
REQ-025 SHALL: MEM asserts dm_req; for sw it also asserts DMWr; the address ALU controls are held as in EXE; it holds until dm_ready=1.
REQ-026 SHALL: on dm_ready=1, MEM goes to WB for lw and to FETCH for sw.
REQ-027 SHALL: WB pulses GRFWr for one cycle with: addu/subu A3Sel=00, WDSel=00; ori A3Sel=01, WDSel=00; lui A3Sel=01, WDSel=11; lw A3Sel=01, WDSel=01.
REQ-028 SHALL: WB for jal also asserts A3Sel=10, WDSel=10, NPCOp=10 and PCWr=1; WB always returns to FETCH.
REQ-029 SHALL: take the following cycle counts, with 0 wait states: beq/jr/jal 3; addu/subu/ori/lui/sw 4; lw 5; each wait cycle adds 1.
REQ-030 SHALL: in every state not listed above, drive each enable, req and illegal output at 0 and each select at 00.
REQ-031 SHALL: ignore a ready input that is asserted without its matching req.
REQ-032 SHALL: treat a simultaneous im_ready and dm_ready exactly as if only the ready of the current state were asserted.

Reset
REQ-033 SHALL: while reset=0, force the state to FETCH and force every output to 0, im_req included, asynchronously.
REQ-034 SHALL: assert im_req on the first rising clk after reset deasserts.
REQ-035 SHALL: when reset is asserted mid-instruction, abandon that instruction with no further PCWr, GRFWr or DMWr.

Configuration
REQ-036 SHALL: when MC_CTRL_PERF_EN is defined, add output instr_cnt [31:0], reset to 0.
REQ-037 SHALL: instr_cnt increments by 1 on every retiring transition into FETCH, excluding illegal instructions, and wraps from FFFFFFFFh to 0.
REQ-038 SHALL: without MC_CTRL_PERF_EN, omit the instr_cnt port and its logic, with no other behavioural change.

Verification
REQ-039 SHALL: reset low mid-MEM of a sw with dm_req=1 -> all outputs 0 immediately; after release, FETCH with im_req=1 and no DMWr issued.
REQ-040 SHALL: addu (opcode 0, funct 21h) with immediate readies -> states FETCH,DCD,EXE,WB; one GRFWr pulse with A3Sel=00, WDSel=00; next FETCH at cycle 5.
REQ-041 SHALL: lw (opcode 23h) with dm_ready delayed 2 cycles -> dm_req high for 3 cycles; GRFWr in WB with A3Sel=01, WDSel=01; total 7 cycles.
REQ-042 SHALL: beq (opcode 04h) -> Zero=1 gives PCWr=1, NPCOp=01 in EXE; Zero=0 gives PCWr=0; both take 3 cycles.
REQ-043 SHALL: jal (opcode 03h) -> WB shows PCWr=1, NPCOp=10, GRFWr=1, A3Sel=10, WDSel=10; opcode 3Fh -> illegal pulse in DCD, no writes, return to FETCH.
REQ-044 SHALL: with MC_CTRL_PERF_EN, preload instr_cnt to FFFFFFFFh and retire one nop -> instr_cnt=0.
